// File: rtl/oc8051_pt_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_pt_loader_pkg
// Brief    : Shared constants, state encoding and window helper for the
//            page-table loader.
// Revision : 1.0 - initial release
// ============================================================================
package oc8051_pt_loader_pkg;

    localparam logic [15:0] c_pt_base     = 16'hFF80;

    localparam logic [1:0]  c_err_none    = 2'd0;
    localparam logic [1:0]  c_err_overlap = 2'd1;
    localparam logic [1:0]  c_err_timeout = 2'd2;
    localparam logic [1:0]  c_err_verify  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
        S_VFY   = 3'd5,
        S_FIN   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Two equal-length windows on a 16-bit ring intersect iff either start
    // lies less than one window length ahead of the other.
    function automatic logic windows_overlap(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [15:0] len);
        logic [15:0] d_ab;
        logic [15:0] d_ba;
        d_ab = b - a;
        d_ba = a - b;
        return (d_ab < len) || (d_ba < len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oc8051_pt_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_bus_timeout
// Brief    : Bus-master ack watchdog; expired fires on the LIMIT-th
//            consecutive waiting cycle of a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module oc8051_bus_timeout #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= 8'd0;
        end else if (run && (r_count != LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = run & ~clr & (r_count == (LIMIT - 8'd1));

endmodule
`default_nettype wire

// File: rtl/oc8051_pt_loader.sv
`default_nettype none
// ============================================================================
// Module   : oc8051_pt_loader
// Brief    : XRAM bus master copying a 64-byte image into the page-table
//            permission registers. Build option OC8051_PT_LOADER_VERIFY_EN
//            adds a read-back check after every page-table write.
// Revision : 1.0 - initial release
// ============================================================================
module oc8051_pt_loader
    import oc8051_pt_loader_pkg::*;
#(
    parameter logic [15:0] PT_BASE  = c_pt_base,
    parameter int          PT_BYTES = 64,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        m_stb,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [7:0]  m_data_out,
    input  logic [7:0]  m_data_in,
    input  logic        m_ack,
    output logic        priv_req
);

    localparam int               IDX_W      = $clog2(PT_BYTES);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(PT_BYTES - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [15:0]      c_win_len  = 16'(PT_BYTES);

    state_t           r_state;
    state_t           r_pend;
    logic [15:0]      r_src;
    logic [15:0]      r_addr;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_latch;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [1:0]       r_err_code;
    logic             r_bus_req;
    logic             r_stb;
    logic             r_wr;
    logic             r_priv;

    logic             w_stb;
    logic             w_strobing;
    logic             w_to_clr;
    logic             w_expired;
    logic             w_step;
    logic             w_fail;
    logic [1:0]       w_fail_code;
    logic [15:0]      w_next_rd_addr;

    // Strobe is gated by grant so a revoked grant silences the bus at once.
    assign w_stb          = r_stb & bus_gnt;
    assign w_strobing     = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_VFY);
    assign w_to_clr       = ~w_stb | m_ack;
    assign w_next_rd_addr = r_src + 16'(r_idx) + 16'd1;

    oc8051_bus_timeout #(
        .LIMIT   (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_to_clr),
        .run     (w_stb),
        .expired (w_expired)
    );

    always_comb begin
        w_step      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = c_err_none;
        case (r_state)
            S_CHECK: begin
                if (windows_overlap(r_src, PT_BASE, c_win_len)) begin
                    w_fail      = 1'b1;
                    w_fail_code = c_err_overlap;
                end
            end
            S_WR: begin
`ifndef OC8051_PT_LOADER_VERIFY_EN
                w_step = w_stb & m_ack;
`endif
            end
`ifdef OC8051_PT_LOADER_VERIFY_EN
            S_VFY: begin
                if (w_stb && m_ack) begin
                    if (m_data_in == r_latch) begin
                        w_step = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = c_err_verify;
                    end
                end
            end
`endif
            default: ;
        endcase
        if (w_strobing && w_expired) begin
            w_fail      = 1'b1;
            w_fail_code = c_err_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pend     <= S_RD;
            r_src      <= 16'd0;
            r_addr     <= 16'd0;
            r_idx      <= '0;
            r_latch    <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= c_err_none;
            r_bus_req  <= 1'b0;
            r_stb      <= 1'b0;
            r_wr       <= 1'b0;
            r_priv     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_fail) begin
                r_state    <= S_ERR;
                r_error    <= 1'b1;
                r_err_code <= w_fail_code;
                r_busy     <= 1'b0;
                r_bus_req  <= 1'b0;
                r_stb      <= 1'b0;
                r_wr       <= 1'b0;
                r_priv     <= 1'b0;
            end else if (w_step) begin
                if (r_idx == c_idx_last) begin
                    r_state   <= S_FIN;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_bus_req <= 1'b0;
                    r_stb     <= 1'b0;
                    r_wr      <= 1'b0;
                    r_priv    <= 1'b0;
                end else begin
                    r_idx   <= r_idx + c_idx_one;
                    r_state <= S_RD;
                    r_wr    <= 1'b0;
                    r_priv  <= 1'b0;
                    r_addr  <= w_next_rd_addr;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_src      <= src_addr;
                            r_error    <= 1'b0;
                            r_err_code <= c_err_none;
                            r_busy     <= 1'b1;
                            r_idx      <= '0;
                            r_pend     <= S_RD;
                            r_state    <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        r_state   <= S_REQ;
                        r_bus_req <= 1'b1;
                        r_wr      <= 1'b0;
                        r_priv    <= 1'b0;
                        r_addr    <= r_src;
                    end
                    S_REQ: begin
                        if (bus_gnt) begin
                            r_state <= r_pend;
                            r_stb   <= 1'b1;
                        end
                    end
                    S_RD, S_WR, S_VFY: begin
                        // Lost grant parks the pending op; address/data stay put for reissue.
                        if (!bus_gnt) begin
                            r_state <= S_REQ;
                            r_pend  <= r_state;
                            r_stb   <= 1'b0;
                        end else if (m_ack) begin
                            if (r_state == S_RD) begin
                                r_latch <= m_data_in;
                                r_state <= S_WR;
                                r_wr    <= 1'b1;
                                r_priv  <= 1'b1;
                                r_addr  <= PT_BASE + 16'(r_idx);
                            end
`ifdef OC8051_PT_LOADER_VERIFY_EN
                            else if (r_state == S_WR) begin
                                r_state <= S_VFY;
                                r_wr    <= 1'b0;
                            end
`endif
                        end
                    end
                    S_FIN, S_ERR: r_state <= S_IDLE;
                    default:      r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign bus_req    = r_bus_req;
    assign m_stb      = w_stb;
    assign m_wr       = r_wr;
    assign m_addr     = r_addr;
    assign m_data_out = r_latch;
    assign priv_req   = r_priv & w_stb;

endmodule
`default_nettype wire
